// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory store path.
// isMisaligned() backs the optional MISALIGN_TRAP_EN alignment check.
package mips_mem_pkg;

  localparam int unsigned HALF_BYTES = 2;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned BE_W       = HALF_BYTES;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } sizeT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } stateT;

  // One 16-bit memory beat payload
  typedef struct packed {
    logic [MEM_DATA_W-1:0] wdata;
    logic [BE_W-1:0]       be;
  } memBeatT;

  // True when the low address bits do not match the natural alignment of size
  function automatic logic isMisaligned(sizeT size, logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF && addrLo[0]) mis = 1'b1;
    if (size == SZ_WORD && addrLo != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/store_lane_mux.sv
// Combinational lane steering: picks the halfword, byte enables and low
// address bits for one memory beat of a byte, half or word store.
module store_lane_mux
  import mips_mem_pkg::*;
(
  input  logic                  beat,
  input  sizeT                  size,
  input  logic [1:0]            addrLo,
  input  logic [REQ_DATA_W-1:0] data,
  output memBeatT               laneBeat_c,
  output logic [1:0]            laneAddrLo_c
);

  always_comb begin
    laneBeat_c   = '0;
    laneAddrLo_c = '0;
    case (size)
      SZ_BYTE: begin
        // Byte is replicated on both lanes; the enable selects the live one
        laneBeat_c.wdata = {data[7:0], data[7:0]};
        laneBeat_c.be    = addrLo[0] ? 2'b10 : 2'b01;
        laneAddrLo_c     = {addrLo[1], 1'b0};
      end
      SZ_HALF: begin
        laneBeat_c.wdata = data[15:0];
        laneBeat_c.be    = 2'b11;
        laneAddrLo_c     = {addrLo[1], 1'b0};
      end
      SZ_WORD: begin
        laneBeat_c.wdata = beat ? data[31:16] : data[15:0];
        laneBeat_c.be    = 2'b11;
        laneAddrLo_c     = {beat, 1'b0};
      end
      default: begin
        laneBeat_c   = '0;
        laneAddrLo_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrower_32to16.sv
// Narrows 32-bit store requests onto a 16-bit memory port with byte enables.
// Define MISALIGN_TRAP_EN to reject misaligned half/word stores with err.
module store_narrower_32to16
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [REQ_DATA_W-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]       mem_be,
  output logic                  done,
  output logic                  err
);

  stateT                  state, stateNext;
  logic [ADDR_W-1:0]      addrQ, addrNext;
  logic [REQ_DATA_W-1:0]  dataQ, dataNext;
  sizeT                   sizeQ, sizeNext;

  logic                   memValidQ, memValidNext;
  logic [ADDR_W-1:0]      memAddrQ, memAddrNext;
  memBeatT                memBeatQ, memBeatNext;
  logic                   doneQ, doneNext;
  logic                   errQ, errNext;
  logic                   reqReadyQ, reqReadyNext;

  logic                   canAccept;
  sizeT                   muxSize;
  logic [1:0]             muxAddrLo;
  logic [ADDR_W-3:0]      muxAddrHi;
  logic [REQ_DATA_W-1:0]  muxData;
  logic                   muxBeat;
  logic                   rejectReq;
  memBeatT                laneBeat_c;
  logic [1:0]             laneAddrLo_c;

  // Lane mux sees the live request when accepting, else the latched one
  assign canAccept = (state == IDLE) || (state == FIN);
  assign muxSize   = canAccept ? sizeT'(req_size) : sizeQ;
  assign muxAddrLo = canAccept ? req_addr[1:0] : addrQ[1:0];
  assign muxAddrHi = canAccept ? req_addr[ADDR_W-1:2] : addrQ[ADDR_W-1:2];
  assign muxData   = canAccept ? req_data : dataQ;
  assign muxBeat   = (state == BEAT0);

`ifdef MISALIGN_TRAP_EN
  assign rejectReq = (muxSize == SZ_RSVD) || isMisaligned(muxSize, muxAddrLo);
`else
  assign rejectReq = (muxSize == SZ_RSVD);
`endif

  store_lane_mux uLaneMux (
    .beat         (muxBeat),
    .size         (muxSize),
    .addrLo       (muxAddrLo),
    .data         (muxData),
    .laneBeat_c   (laneBeat_c),
    .laneAddrLo_c (laneAddrLo_c)
  );

  // Next-state and next-output logic
  always_comb begin
    stateNext   = state;
    addrNext    = addrQ;
    dataNext    = dataQ;
    sizeNext    = sizeQ;
    errNext     = 1'b0;
    memAddrNext = '0;
    memBeatNext = '0;

    case (state)
      IDLE, FIN: begin
        stateNext = IDLE;
        if (req_valid) begin
          if (rejectReq) begin
            errNext = 1'b1;
          end else begin
            stateNext = BEAT0;
            addrNext  = req_addr;
            dataNext  = req_data;
            sizeNext  = muxSize;
          end
        end
      end
      BEAT0: if (mem_ready) stateNext = (sizeQ == SZ_WORD) ? BEAT1 : FIN;
      BEAT1: if (mem_ready) stateNext = FIN;
      default: stateNext = IDLE;
    endcase

    memValidNext = (stateNext == BEAT0) || (stateNext == BEAT1);
    reqReadyNext = !memValidNext;
    doneNext     = (stateNext == FIN);

    if (memValidNext) begin
      // A stalled beat keeps its payload; otherwise load the upcoming beat
      if (((state == BEAT0) || (state == BEAT1)) && !mem_ready) begin
        memAddrNext = memAddrQ;
        memBeatNext = memBeatQ;
      end else begin
        memAddrNext = {muxAddrHi, laneAddrLo_c};
        memBeatNext = laneBeat_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addrQ     <= '0;
      dataQ     <= '0;
      sizeQ     <= SZ_BYTE;
      memValidQ <= 1'b0;
      memAddrQ  <= '0;
      memBeatQ  <= '0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      reqReadyQ <= 1'b1;
    end else begin
      state     <= stateNext;
      addrQ     <= addrNext;
      dataQ     <= dataNext;
      sizeQ     <= sizeNext;
      memValidQ <= memValidNext;
      memAddrQ  <= memAddrNext;
      memBeatQ  <= memBeatNext;
      doneQ     <= doneNext;
      errQ      <= errNext;
      reqReadyQ <= reqReadyNext;
    end
  end

  assign req_ready = reqReadyQ;
  assign mem_valid = memValidQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memBeatQ.wdata;
  assign mem_be    = memBeatQ.be;
  assign done      = doneQ;
  assign err       = errQ;

endmodule

// File: tb/tb_store_narrower_32to16.sv
// Bench for store_narrower_32to16: queue-of-beats reference model checked every
// cycle, plus directed literal checks. Honours MISALIGN_TRAP_EN if defined.
module tb_store_narrower_32to16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  store_narrower_32to16 #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of outstanding beats ----------------
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } beatT;

  beatT beatQ[$];
  logic expValid = 1'b0;
  logic expDone  = 1'b0;
  logic expErr   = 1'b0;
  logic expReady = 1'b0;
  bit   armed    = 1'b0;

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic bit modelReject(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return (sz == 2'd3) || misaligned(sz, a);
`else
    return (sz == 2'd3);
`endif
  endfunction

  task automatic pushBeats(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    beatT b;
    case (sz)
      2'd0: begin
        b.a  = a - a % 2;
        b.d  = 16'((d % 256) * 257);
        b.be = (a % 2 == 1) ? 2'b10 : 2'b01;
        beatQ.push_back(b);
      end
      2'd1: begin
        b.a  = a - a % 2;
        b.d  = 16'(d % 65536);
        b.be = 2'b11;
        beatQ.push_back(b);
      end
      default: begin
        b.a  = a - a % 4;
        b.d  = 16'(d % 65536);
        b.be = 2'b11;
        beatQ.push_back(b);
        b.a  = b.a + 2;
        b.d  = 16'(d / 65536);
        beatQ.push_back(b);
      end
    endcase
  endtask

  task automatic modelStep();
    bit popDone;
    bit newErr;
    if (rst) begin
      beatQ.delete();
      expValid = 1'b0;
      expDone  = 1'b0;
      expErr   = 1'b0;
      expReady = 1'b1;
      armed    = 1'b1;
      return;
    end
    if (!armed) return;
    popDone = 1'b0;
    newErr  = 1'b0;
    if (beatQ.size() > 0 && mem_ready) begin
      void'(beatQ.pop_front());
      if (beatQ.size() == 0) popDone = 1'b1;
    end
    if (expReady && req_valid) begin
      if (modelReject(req_size, req_addr)) newErr = 1'b1;
      else pushBeats(req_size, req_addr, req_data);
    end
    expDone  = popDone;
    expErr   = newErr;
    expValid = (beatQ.size() > 0);
    expReady = !expValid;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("m_valid", 32'(mem_valid), 32'(expValid));
      check("m_done",  32'(done),      32'(expDone));
      check("m_err",   32'(err),       32'(expErr));
      check("m_ready", 32'(req_ready), 32'(expReady));
      if (expValid && beatQ.size() > 0) begin
        check("m_addr",  mem_addr,        beatQ[0].a);
        check("m_wdata", 32'(mem_wdata),  32'(beatQ[0].d));
        check("m_be",    32'(mem_be),     32'(beatQ[0].be));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  logic [31:0] tA[8];
  logic [31:0] tD[8];
  logic [1:0]  tS[8];

  initial begin
    int doneCount;
    int w;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_addr",  mem_addr,       32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Byte store to odd address
    present(32'h0000_1003, 32'h1234_56AB, 2'b00);
    check("byte_valid", 32'(mem_valid), 32'd1);
    check("byte_addr",  mem_addr,       32'h0000_1002);
    check("byte_wdata", 32'(mem_wdata), 32'h0000_ABAB);
    check("byte_be",    32'(mem_be),    32'd2);
    check("byte_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("byte_done",  32'(done),      32'd1);
    check("byte_fin_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);
    check("byte_done_clear", 32'(done), 32'd0);

    // Word store, two beats
    present(32'h0000_2000, 32'hDEAD_BEEF, 2'b10);
    check("word_b0_addr",  mem_addr,       32'h0000_2000);
    check("word_b0_wdata", 32'(mem_wdata), 32'h0000_BEEF);
    check("word_b0_be",    32'(mem_be),    32'd3);
    @(negedge clk);
    check("word_b1_addr",  mem_addr,       32'h0000_2002);
    check("word_b1_wdata", 32'(mem_wdata), 32'h0000_DEAD);
    check("word_b1_done",  32'(done),      32'd0);
    @(negedge clk);
    check("word_done",     32'(done),      32'd1);
    check("word_fin_valid", 32'(mem_valid), 32'd0);
    @(negedge clk);

    // Word store with three stall cycles on the second beat
    present(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(mem_valid), 32'd1);
      check("stall_addr",  mem_addr,       32'h0000_3002);
      check("stall_wdata", 32'(mem_wdata), 32'h0000_CAFE);
      check("stall_done",  32'(done),      32'd0);
      if (i == 3) mem_ready = 1'b1;
      @(negedge clk);
    end
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) doneCount++;
      @(negedge clk);
    end
    check("stall_done_once", 32'(doneCount), 32'd1);

    // Misaligned halfword
    present(32'h0000_0011, 32'h5555_A5A5, 2'b01);
`ifdef MISALIGN_TRAP_EN
    check("half_mis_err",   32'(err),       32'd1);
    check("half_mis_valid", 32'(mem_valid), 32'd0);
    check("half_mis_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("half_mis_err_clear", 32'(err), 32'd0);
`else
    check("half_mis_valid", 32'(mem_valid), 32'd1);
    check("half_mis_addr",  mem_addr,       32'h0000_0010);
    check("half_mis_wdata", 32'(mem_wdata), 32'h0000_A5A5);
    check("half_mis_be",    32'(mem_be),    32'd3);
    @(negedge clk);
    check("half_mis_done",  32'(done),      32'd1);
`endif
    @(negedge clk);

    // Reserved size
    present(32'h0000_0040, 32'h0000_0000, 2'b11);
    check("rsvd_err",   32'(err),       32'd1);
    check("rsvd_valid", 32'(mem_valid), 32'd0);
    check("rsvd_done",  32'(done),      32'd0);
    check("rsvd_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("rsvd_err_clear", 32'(err), 32'd0);
    check("rsvd_no_beat",   32'(mem_valid), 32'd0);

    // Reset during the second beat of a word store
    present(32'h0000_4000, 32'h1111_2222, 2'b10);
    @(negedge clk);
    check("rstmid_b1_addr", mem_addr, 32'h0000_4002);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_valid", 32'(mem_valid), 32'd0);
    check("rstmid_done",  32'(done),      32'd0);
    check("rstmid_err",   32'(err),       32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_addr",  mem_addr,       32'd0);
    check("rstmid_wdata", 32'(mem_wdata), 32'd0);
    check("rstmid_be",    32'(mem_be),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_no_done", 32'(done), 32'd0);

    // Back-to-back: second request presented in the done cycle
    present(32'h0000_1000, 32'h0000_00CC, 2'b00);
    check("bb_a_addr",  mem_addr,       32'h0000_1000);
    check("bb_a_wdata", 32'(mem_wdata), 32'h0000_CCCC);
    check("bb_a_be",    32'(mem_be),    32'd1);
    @(negedge clk);
    check("bb_a_done",  32'(done),      32'd1);
    check("bb_a_ready", 32'(req_ready), 32'd1);
    present(32'h0000_0020, 32'h7777_BEEF, 2'b01);
    check("bb_b_valid", 32'(mem_valid), 32'd1);
    check("bb_b_addr",  mem_addr,       32'h0000_0020);
    check("bb_b_wdata", 32'(mem_wdata), 32'h0000_BEEF);
    check("bb_b_done",  32'(done),      32'd0);
    @(negedge clk);
    check("bb_b_done2", 32'(done),      32'd1);

    // Mixed stream with random memory back-pressure; model checks every cycle
    tA[0] = 32'h0000_5000; tD[0] = 32'h89AB_CDEF; tS[0] = 2'b10;
    tA[1] = 32'h0000_5001; tD[1] = 32'h0000_0042; tS[1] = 2'b00;
    tA[2] = 32'h0000_5006; tD[2] = 32'h0102_0304; tS[2] = 2'b10;
    tA[3] = 32'h0000_5008; tD[3] = 32'hFFFF_1357; tS[3] = 2'b01;
    tA[4] = 32'h0000_500C; tD[4] = 32'h0000_0000; tS[4] = 2'b11;
    tA[5] = 32'h0000_500E; tD[5] = 32'h5A5A_0F0F; tS[5] = 2'b01;
    tA[6] = 32'h0000_6004; tD[6] = 32'h0BAD_F00D; tS[6] = 2'b10;
    tA[7] = 32'h0000_6002; tD[7] = 32'h0000_0099; tS[7] = 2'b00;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (!req_ready && w < 20) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        w++;
      end
      check("mix_ready_wait", 32'(req_ready), 32'd1);
      if (req_ready) present(tA[k], tD[k], tS[k]);
    end
    mem_ready = 1'b1;
    w = 0;
    while ((!req_ready || mem_valid) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mix_drain", 32'(req_ready && !mem_valid), 32'd1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/store_narrower_32to16.md
# store_narrower_32to16

Store-path narrowing unit for the MIPS datapath; the write-side counterpart of the load/immediate sign-extension path. It accepts a 32-bit store request with a size code and drives a 16-bit-wide data memory port with byte enables. Byte and halfword stores take one memory beat; word stores are split into two halfword beats. It sits between the EX/MEM stage store logic and the data memory model.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of request and memory ports

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  byte address
- req_data  in  32  store data; used from bit 0 upward
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_valid  out  1  memory beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  ADDR_W  halfword-aligned address; bit 0 always 0
- mem_wdata  out  16  write data
- mem_be  out  2  byte enables; bit 0 = low byte, little-endian
- done  out  1  one-cycle pulse: store completed
- err  out  1  one-cycle pulse: request rejected, no memory access

## Operation
- FSM states: IDLE, BEAT0, BEAT1, FIN.
- IDLE: req_ready=1. On req_valid: latch addr/data/size and go to BEAT0; if rejected, pulse err next cycle and stay in IDLE.
- Lane mapping:
  - Byte: mem_addr={addr[W-1:1],0}, mem_wdata={data[7:0],data[7:0]}, mem_be = addr[0] ? 10 : 01.
  - Half: mem_wdata=data[15:0], mem_be=11.
  - Word: BEAT0 addr={addr[W-1:2],00}, data[15:0]; BEAT1 addr+2, data[31:16]; both be=11.
- BEAT0/BEAT1: mem_valid=1; addr/wdata/be held stable until mem_ready. Byte/half go BEAT0→FIN; word goes BEAT0→BEAT1→FIN.
- FIN: done=1, req_ready=1. A request presented here is accepted and goes directly to BEAT0, giving back-to-back operation.
- Size 11: always rejected with err; no beat issued.
- mem_valid, done and err are never asserted together.
- Reset: every output is 0 except req_ready, which is 1 from the first cycle after reset. State returns to IDLE. Reset mid-operation abandons the store; no done pulse is produced and a partial word write is not completed.

## Timing
- Request accepted at edge N → mem_valid high in cycle N+1 (registered outputs, no combinational path from req_* to mem_*).
- mem_ready tied 1: byte/half done in N+2; word beats in N+1 and N+2, done in N+3.
- Each cycle with mem_ready=0 extends the current beat by one cycle.
- Rejection: err in cycle N+1; req_ready stays 1.
- Sustained throughput with mem_ready=1: one byte/half store every 2 cycles; one word store every 3 cycles.

## Configuration
- MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1 is rejected with err.
  - Word with addr[1:0]≠00 is rejected with err.
- Not defined:
  - Misaligned low address bits are silently cleared (half ignores bit 0; word ignores bits 1:0).
  - err fires only for size 11.

## Structure
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - FSM state enum
  - HALF_BYTES=2 constant
- One natural sub-module, store_lane_mux: combinational lane/byte-enable generator from (beat, size, addr[1:0], data). The top holds the FSM and output registers.

## Test plan
- Byte store, addr 0x0000_1003, data 0x1234_56AB, mem_ready=1 → one beat: addr 0x1002, wdata 0xABAB, be 10; done in N+2.
- Word store, addr 0x0000_2000, data 0xDEAD_BEEF → beats: (0x2000, 0xBEEF, 11) then (0x2002, 0xDEAD, 11); done in N+3.
- Word store with mem_ready low for 3 cycles on BEAT1 → BEAT1 outputs held stable for 4 cycles; done exactly once.
- Half store, addr 0x11 → with MISALIGN_TRAP_EN: err in N+1, no mem_valid. Without it: beat at 0x10, be 11.
- Size 11 → err pulse, no beat. rst asserted during BEAT1 of a word store → outputs 0 next cycle, req_ready 1, no done.
- Back-to-back: second request presented in the FIN cycle → accepted; its BEAT0 is in the following cycle.
